// File: rtl/textlcd_rx_pkg.sv
// textlcd_rx_pkg: shared opcodes, address map, FSM encoding and helpers for the text-LCD responder
package textlcd_pkg;

    localparam logic [7:0] OP_CLR   = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;
    localparam int         LINE_LEN   = 16;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {INIT_FILL, IDLE, CLR_FILL, BUSY_WAIT} state_t;

    typedef enum logic [3:0] {
        I_NOP, I_CLR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
    } instr_t;

    // The highest set bit of an instruction byte selects the command.
    function automatic instr_t decode(input logic [7:0] d);
        return |(d & OP_DDRAM) ? I_DDRAM :
               |(d & OP_CGRAM) ? I_CGRAM :
               |(d & OP_FUNC)  ? I_FUNC  :
               |(d & OP_SHIFT) ? I_SHIFT :
               |(d & OP_DISP)  ? I_DISP  :
               |(d & OP_ENTRY) ? I_ENTRY :
               |(d & OP_HOME)  ? I_HOME  :
               |(d & OP_CLR)   ? I_CLR   : I_NOP;
    endfunction

    // DDRAM addresses that exist on a 2-line controller.
    function automatic logic ac_legal(input logic [6:0] a);
        return (a <= LINE0_LAST) || (a >= LINE1_BASE && a <= LINE1_LAST);
    endfunction

endpackage

// File: rtl/textlcd_rx_if.sv
// textlcd_rx_if: HD44780-style 8-bit bus between a host driver and the LCD model
interface textlcd_rx_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data_in, input lcd_data_out, lcd_data_oe);
    modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_data_in, output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/textlcd_rx_ac_next.sv
// textlcd_ac_next: next address-counter value with line wrap and illegal-address clamp
module textlcd_ac_next
    import textlcd_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       inc,
    input  logic       step,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] ac_nx
);

    logic [6:0] up;
    logic [6:0] dn;

    // Steps jump between the two 40-byte line segments; loads outside them clamp to 0.
    always_comb begin
        up    = (ac == LINE0_LAST) ? LINE1_BASE : (ac == LINE1_LAST) ? LINE0_BASE : ac + 7'd1;
        dn    = (ac == LINE0_BASE) ? LINE1_LAST : (ac == LINE1_BASE) ? LINE0_LAST : ac - 7'd1;
        ac_nx = load ? (ac_legal(load_val) ? load_val : LINE0_BASE) : step ? (inc ? up : dn) : ac;
    end

endmodule

// File: rtl/textlcd_rx.sv
// textlcd_rx: HD44780-style LCD controller model decoding host bus writes into a 2x16 buffer
module textlcd_rx
    import textlcd_pkg::*;
#(
    parameter int BUSY_SHORT  = 40,
    parameter int BUSY_LONG   = 1520,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    textlcd_rx_if.slave       bus,
    input  logic [4:0]        rd_idx,
    output logic [7:0]        rd_char,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              two_line,
    output logic [6:0]        addr_cnt,
    output logic              busy,
    output logic              cmd_err
);

    localparam int CW = $clog2(BUSY_LONG + 1);

    logic [10:0]   bus_sh [SYNC_STAGES];
    logic [10:0]   bus_d;
    logic          e_s, rs_s, rw_s;
    logic          fall, f_rs, f_rw;
    logic [7:0]    f_d;
    logic          wr_ok, wr_err, rd_ev, cmd_ev, dat_wr, ac_step, ac_load, vis;
    logic [4:0]    ac_idx;
    logic [6:0]    ac_nx;
    instr_t        op;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    fill_idx;
    logic          id;
    logic [7:0]    buf_q [32];

    // E, RS, RW and DATA share one delay line so they stay aligned; bus_d holds the last E-high sample.
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) bus_sh[i] <= '0;
            bus_d <= '0;
        end else begin
            bus_sh[0] <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) bus_sh[i] <= bus_sh[i-1];
            bus_d <= bus_sh[SYNC_STAGES-1];
        end
    end

    // Transaction qualification on the synchronized falling edge of E.
    always_comb begin
        e_s     = bus_sh[SYNC_STAGES-1][10];
        rs_s    = bus_sh[SYNC_STAGES-1][9];
        rw_s    = bus_sh[SYNC_STAGES-1][8];
        fall    = bus_d[10] & ~e_s;
        f_rs    = bus_d[9];
        f_rw    = bus_d[8];
        f_d     = bus_d[7:0];
        op      = decode(f_d);
        wr_ok   = fall & ~f_rw & ~busy;
        wr_err  = fall & ~f_rw & busy;
        rd_ev   = fall & f_rw;
        cmd_ev  = wr_ok & ~f_rs;
        dat_wr  = wr_ok & f_rs;
        ac_step = (wr_ok | rd_ev) & f_rs;
        ac_load = cmd_ev & (op == I_DDRAM);
        vis     = {1'b0, addr_cnt[5:0]} < 7'(LINE_LEN);
        ac_idx  = {addr_cnt[6], addr_cnt[3:0]};
    end

    textlcd_ac_next u_ac_next (
        .ac       (addr_cnt),
        .inc      (id),
        .step     (ac_step),
        .load     (ac_load),
        .load_val (f_d[6:0]),
        .ac_nx    (ac_nx)
    );

    // Control FSM: fills, busy countdown, instruction execution and flag registers.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= INIT_FILL;
            busy      <= 1'b1;
            cnt       <= CW'(BUSY_LONG);
            fill_idx  <= '0;
            addr_cnt  <= '0;
            id        <= 1'b1;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            two_line  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= wr_err | (cmd_ev & (op == I_FUNC) & ~f_d[4]);
            if (ac_step | ac_load) addr_cnt <= ac_nx;
            if (cmd_ev) begin
                if (op == I_ENTRY) id <= f_d[1];
                if (op == I_DISP) {disp_on, cursor_on, blink_on} <= f_d[2:0];
                if (op == I_FUNC) two_line <= f_d[3];
                if (op == I_CLR) id <= 1'b1;
                if (op == I_CLR || op == I_HOME) addr_cnt <= '0;
                busy     <= 1'b1;
                state    <= (op == I_CLR) ? CLR_FILL : BUSY_WAIT;
                cnt      <= (op == I_CLR || op == I_HOME) ? CW'(BUSY_LONG) : CW'(BUSY_SHORT);
                fill_idx <= '0;
            end else if (dat_wr) begin
                busy  <= 1'b1;
                state <= BUSY_WAIT;
                cnt   <= CW'(BUSY_SHORT);
            end else if (state != IDLE) begin
                cnt <= cnt - CW'(1);
                if (state == INIT_FILL || state == CLR_FILL) begin
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) state <= BUSY_WAIT;
                end else if (cnt <= CW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

    // Character buffer: fill writes win over host data writes; mirror port always answers.
    always_ff @(posedge clk) begin
        if (state == INIT_FILL || state == CLR_FILL) buf_q[fill_idx] <= SPACE_CHAR;
        else if (dat_wr && vis) buf_q[ac_idx] <= f_d;
        rd_char <= buf_q[rd_idx];
    end

    // Read return: busy/AC for instruction reads, character at AC for data reads.
    always_ff @(posedge clk) begin
        if (resetn) begin
            bus.lcd_data_oe  <= 1'b0;
            bus.lcd_data_out <= '0;
        end else begin
            bus.lcd_data_oe  <= e_s & rw_s;
            bus.lcd_data_out <= rs_s ? (vis ? buf_q[ac_idx] : SPACE_CHAR) : {busy, addr_cnt};
        end
    end

endmodule

// File: doc/textlcd_rx.md
Name: textlcd_rx

Overview:
- Responder end of the HD44780-style 8-bit text-LCD bus; models the LCD controller, not the host.
- Samples LCD_E/RS/RW/DATA driven by the text-LCD drivers and decodes commands and data writes into a 2x16 character buffer.
- Exposes display flags and a buffer read port for on-board mirroring (7-seg/VGA) and for self-checking benches of the drivers.
- Answers busy-flag/address and data reads when the bus is in read mode.

Parameters:
BUSY_SHORT, 40, clk cycles busy after any non-clear/home instruction or data access
BUSY_LONG, 1520, clk cycles busy after clear/return-home; must be >= 32
SYNC_STAGES, 2, synchronizer depth on lcd_e

Ports:
clk  in  1  system clock; must be >= 4x lcd_e toggle rate
resetn  in  1  reset, synchronous, active-high (asserted = 1)
lcd_e  in  1  bus enable from host
lcd_rs  in  1  0 = instruction, 1 = data
lcd_rw  in  1  0 = write, 1 = read
lcd_data_in  in  8  host-driven bus value
lcd_data_out  out  8  read-return value
lcd_data_oe  out  1  high while returning a read
rd_idx  in  5  buffer index: [4] = line, [3:0] = column
rd_char  out  8  buffer byte at rd_idx, registered, 1-cycle latency
disp_on, cursor_on, blink_on  out  1 each  from display on/off command
two_line  out  1  N bit of function set
addr_cnt  out  7  current address counter (AC)
busy  out  1  busy flag
cmd_err  out  1  1-cycle pulse: write accepted while busy, or 4-bit function set

Behaviour:
- Reset (resetn = 1 at clk edge): AC = 0, I/D = 1, all flags 0, lcd_data_oe = 0, lcd_data_out = 0.
  - FSM enters INIT_FILL; busy = 1.
- Edge detect:
  - lcd_e passes through a SYNC_STAGES synchronizer.
  - RS/RW/DATA are delayed by the same number of stages for alignment.
  - A transaction executes on the synchronized falling edge of lcd_e.
- FSM states: INIT_FILL, IDLE, CLR_FILL, BUSY_WAIT.
  - INIT_FILL / CLR_FILL: write 0x20 to index 0..31, one per cycle (32 cycles), then go to BUSY_WAIT.
  - BUSY_WAIT: count down the remaining busy cycles, then go to IDLE. Counter is loaded with BUSY_LONG at the start of a fill, so the total busy time is BUSY_LONG.
  - IDLE: busy = 0.
- Any write falling edge while busy: ignored, cmd_err pulses, and the busy counter is not extended.
- Instruction decode, highest set bit wins:
  - 0x01 clear: AC = 0, I/D = 1, go to CLR_FILL.
  - 0x02/0x03 home: AC = 0, BUSY_LONG.
  - 0x04-0x07 entry: I/D = bit1; S bit ignored.
  - 0x08-0x0F: disp_on = b2, cursor_on = b1, blink_on = b0.
  - 0x10-0x1F shift: no effect beyond BUSY_SHORT.
  - 0x20-0x3F function set: two_line = b3; b4 = 0 raises cmd_err.
  - 0x40-0x7F CGRAM: ignored, BUSY_SHORT.
  - 0x80-0xFF: AC = data[6:0]. Illegal AC (0x28-0x3F, 0x68-0x7F) loads 0x00.
  - All instructions except clear/home load BUSY_SHORT.
- Data write (RS = 1, RW = 0):
  - If AC[5:4] == 0, buffer[{AC[6], AC[3:0]}] = data.
  - AC steps per I/D; BUSY_SHORT.
- AC stepping:
  - Increment wraps 0x27 -> 0x40 and 0x67 -> 0x00.
  - Decrement wraps 0x00 -> 0x67 and 0x40 -> 0x27.
- Reads (RW = 1) are accepted even while busy.
  - lcd_data_oe = 1 while synchronized E = 1 and RW = 1.
  - RS = 0: lcd_data_out = {busy, AC}.
  - RS = 1: lcd_data_out = buffer char at AC (0x20 if outside the visible window); AC steps on the falling edge.
- rd_idx read port is independent of the bus. Fill writes take priority for buffer write, but the read port always returns a value.
- Reset mid-fill or mid-busy restarts INIT_FILL.

Decomposition:
- Package textlcd_pkg:
  - instruction opcode masks (CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM)
  - line base addresses 0x00 / 0x40, line length 16, wrap limits 0x27 / 0x67
  - FSM state encoding
  - space char 0x20
- Sub-module textlcd_ac_next: combinational next-AC (step/wrap/illegal clamp).

Test Plan:
- Reset, wait BUSY_LONG -> busy falls at cycle BUSY_LONG; all 32 rd_char = 0x20.
- Writes 0x3C, 0x0C, 0x06, 0x80, then data "R","O" -> two_line = 1, disp_on = 1, cursor_on = 0; rd_idx 0 = 0x52, rd_idx 1 = 0x4F; addr_cnt = 0x02.
- 0xC0 then 16 data 0x41 -> rd_idx 16..31 = 0x41; addr_cnt = 0x50.
- AC = 0x27 with data write -> addr_cnt = 0x40, buffer unchanged. Entry 0x04 at AC = 0x00 with data write -> addr_cnt = 0x67.
- Write during busy after 0x01 -> cmd_err single pulse; buffer all 0x20 after fill.
- Read RS = 0 with E high mid-clear -> lcd_data_oe = 1, lcd_data_out[7] = 1, lcd_data_out[6:0] = 0x00.
